// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential word fetches, queues in-order responses,
// and presents one instruction per cycle with its PC and PC+8; a redirect flushes stale work.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc8,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [31:0]       q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  logic [CW:0]       occupancy;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              req_fire;
  logic              push;
  logic              pop;

  // Queued plus in-flight work is capped at DEPTH so a response always has a free slot.
  assign occupancy        = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid   = ~reset & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  assign push = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign pop  = instr_valid & instr_ready & ~redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign instr_pc8   = instr_pc + ADDR_W'(8);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire && !imem_resp_valid)
        inflight <= inflight + CW'(1);
      else if (!req_fire && imem_resp_valid)
        inflight <= inflight - CW'(1);

      if (redirect_valid) begin
        // Everything still outstanding belongs to the old path, except a word landing now.
        drop_cnt <= inflight - {{(CW-1){1'b0}}, imem_resp_valid};
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + ADDR_W'(4);
        if (imem_resp_valid && drop_cnt != '0)
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + ADDR_W'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule
